// File: rtl/quadra_out_fifo.sv
// Elastic output buffer for the quadra pipeline: first-word-fall-through FIFO with registered outputs and sticky overflow.
// Optional drop counter is enabled by defining QUADRA_OFIFO_DROP_CNT_EN.
`timescale 1ns/1ps
module quadra_out_fifo #(
    parameter int Y_W   = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [Y_W-1:0]           y_i,
    input  logic                     y_dv_i,
    output logic [Y_W-1:0]           m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     ovf_o,
    input  logic                     clr_ovf_i,
    output logic [15:0]              drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [Y_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [Y_W-1:0] data_q, data_d;
    logic           valid_q, valid_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic           ovf_q, ovf_d;
    logic           push, pop, drop;

    always_comb begin
        pop      = valid_q & m_ready_i;
        push     = y_dv_i & (~full_q | pop);
        drop     = y_dv_i & full_q & ~pop;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        valid_d = (level_d != '0);
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == '0);
        // Next head is the sample being written this cycle when it lands in the head slot.
        data_d = data_q;
        if (valid_d)
            data_d = (push && (wr_ptr_q == rd_ptr_d)) ? y_i : mem_q[rd_ptr_d];
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (clr_ovf_i)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= y_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef QUADRA_OFIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // A drop coinciding with a clear restarts the count at one.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop)
            drop_cnt_d = clr_ovf_i ? 16'd1 :
                         (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
        else if (clr_ovf_i)
            drop_cnt_d = 16'd0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drop_cnt_q <= 16'd0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = 16'd0;
`endif

    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign level_o   = level_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_quadra_out_fifo.sv
// Directed bench for quadra_out_fifo: reset, latency, wrap, full push+pop, overflow and a random backpressure scoreboard.
`timescale 1ns/1ps
module tb_quadra_out_fifo;
    localparam int Y_W   = 32;
    localparam int DEPTH = 8;
`ifdef QUADRA_OFIFO_DROP_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [Y_W-1:0]   y = '0;
    logic             y_dv = 1'b0;
    logic [Y_W-1:0]   m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [3:0]       level;
    logic             full, empty, ovf;
    logic             clr_ovf = 1'b0;
    logic [15:0]      drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    quadra_out_fifo #(.Y_W(Y_W), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .y_i(y), .y_dv_i(y_dv),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .level_o(level), .full_o(full), .empty_o(empty), .ovf_o(ovf),
        .clr_ovf_i(clr_ovf), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int base, input int n);
        m_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            y_dv = 1'b1;
            y    = base + i;
            step();
        end
        y_dv = 1'b0;
    endtask

    task automatic drain_chk(input int base, input int n);
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("drain_valid", m_valid, 1);
            chk("drain_data", m_data, base + i);
            step();
        end
        m_ready = 1'b0;
    endtask

    int q[$];
    int pushed;
    int cycles;

    initial begin
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_cnt", drop_cnt, 0);

        // mid-stream reset with 5 stored
        push_n(100, 5);
        chk("t1_level5", level, 5);
        chk("t1_head", m_data, 100);
        rst = 1'b1;
        step();
        chk("t1_level", level, 0);
        chk("t1_empty", empty, 1);
        chk("t1_valid", m_valid, 0);
        chk("t1_data", m_data, 0);
        rst = 1'b0;
        step();
        chk("t1_still_empty", empty, 1);

        // latency and order
        m_ready = 1'b1;
        y_dv = 1'b1;
        y = 1; step(); chk("t2_v1", m_valid, 1); chk("t2_d1", m_data, 1);
        y = 2; step(); chk("t2_v2", m_valid, 1); chk("t2_d2", m_data, 2);
        y = 3; step(); chk("t2_v3", m_valid, 1); chk("t2_d3", m_data, 3);
        y_dv = 1'b0;
        step(); chk("t2_v4", m_valid, 0);
        m_ready = 1'b0;

        // fill, drain, refill twice (pointers wrap)
        for (int r = 0; r < 3; r++) begin
            push_n(10 + 10 * r, 8);
            chk("t3_full", full, 1);
            chk("t3_level", level, 8);
            drain_chk(10 + 10 * r, 8);
            chk("t3_empty", empty, 1);
            chk("t3_valid0", m_valid, 0);
        end

        // full with simultaneous push and pop
        push_n(40, 8);
        y_dv = 1'b1; y = 99; m_ready = 1'b1;
        step();
        y_dv = 1'b0; m_ready = 1'b0;
        chk("t4_level", level, 8);
        chk("t4_full", full, 1);
        chk("t4_ovf", ovf, 0);
        chk("t4_head", m_data, 41);
        drain_chk(41, 7);
        drain_chk(99, 1);
        chk("t4_empty", empty, 1);

        // overflow and clear-vs-drop priority
        push_n(50, 8);
        y_dv = 1'b1;
        y = 60; step();
        chk("t5_ovf1", ovf, 1);
        chk("t5_cnt1", drop_cnt, CNT_ON ? 1 : 0);
        y = 61; step();
        y = 62; step();
        chk("t5_ovf3", ovf, 1);
        chk("t5_cnt3", drop_cnt, CNT_ON ? 3 : 0);
        chk("t5_level", level, 8);
        chk("t5_head", m_data, 50);
        y = 63; clr_ovf = 1'b1; step();
        chk("t5_clr_drop_ovf", ovf, 1);
        chk("t5_clr_drop_cnt", drop_cnt, CNT_ON ? 1 : 0);
        y_dv = 1'b0; step();
        clr_ovf = 1'b0;
        chk("t5_clr_ovf", ovf, 0);
        chk("t5_clr_cnt", drop_cnt, 0);
        drain_chk(50, 8);
        chk("t5_empty", empty, 1);

        // random backpressure scoreboard
        pushed = 0;
        cycles = 0;
        while (pushed < 1000 && cycles < 20000) begin
            chk("t6_valid", m_valid, (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) chk("t6_data", m_data, q[0]);
            chk("t6_ovf", ovf, 0);
            m_ready = ($urandom_range(0, 1) == 1);
            y_dv    = ($urandom_range(0, 1) == 1) && (q.size() < DEPTH);
            y       = $urandom;
            if (q.size() != 0 && m_ready) void'(q.pop_front());
            if (y_dv) begin
                q.push_back(y);
                pushed++;
            end
            step();
            cycles++;
        end
        chk("t6_pushed", pushed, 1000);
        y_dv = 1'b0;
        m_ready = 1'b1;
        cycles = 0;
        while (q.size() != 0 && cycles < 20) begin
            chk("t6_tail", m_data, q[0]);
            void'(q.pop_front());
            step();
            cycles++;
        end
        m_ready = 1'b0;
        chk("t6_empty", empty, 1);
        chk("t6_ovf_end", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
